csi_tx_lane_dist: RTL and testbench

- Transmit-side lane distributor for the CSI-2 link: it takes packet words already split one byte per lane and builds the per-lane HS burst for the D-PHY serializers.
- Each burst is HS-zero leader, then SoT sync byte 0xB8 on every lane, then payload, then HS-trail with per-lane bit inversion.
- Sits between the packet builder (header/ECC/CRC) and the per-lane OSERDES blocks.
- It is the transmit counterpart of the receive path's per-lane sync detection and lane word alignment.

---
 rtl/csi_tx_lane_dist.sv | 154 +++++++++++++++
 tb/tb_csi_tx_lane_dist.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/csi_tx_lane_dist.sv
`default_nettype none
// ============================================================================
// Module   : csi_tx_lane_dist
// Brief    : CSI-2 transmit lane distributor; builds per-lane D-PHY HS bursts
//            (HS-zero leader, 0xB8 sync, payload, inverted-bit HS-trail).
// Revision : 1.0 - initial release
// ============================================================================
module csi_tx_lane_dist #(
    parameter int NUM_LANE     = 2,
    parameter int ZERO_CYCLES  = 4,
    parameter int TRAIL_CYCLES = 3
) (
    input  logic                              byte_clock,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [8*NUM_LANE-1:0]             word_in,
    input  logic                              last_in,
    input  logic [$clog2(NUM_LANE+1)-1:0]     last_lanes,
    output logic                              hs_en_out,
    output logic [8*NUM_LANE-1:0]             word_out,
    output logic [NUM_LANE-1:0]               valid_out,
    output logic                              err_underrun
);

    localparam int         LANE_W    = $clog2(NUM_LANE + 1);
    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ZERO  = 3'd1,
        DATA  = 3'd2,
        TRAIL = 3'd3,
        EXIT  = 3'd4
    } state_t;

    state_t                  state, state_nxt;
    logic [7:0]              cnt, cnt_nxt;
    logic [8*NUM_LANE-1:0]   word_nxt;
    logic [NUM_LANE-1:0]     valid_nxt;
    logic                    hs_nxt;
    // bit 7 of the most recent valid byte sent on each lane
    logic [NUM_LANE-1:0]     last_msb, msb_nxt;

    function automatic logic [7:0] trail_byte(input logic msb);
        return msb ? 8'h00 : 8'hFF;
    endfunction

    always_ff @(posedge byte_clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            word_out  <= '0;
            valid_out <= '0;
            hs_en_out <= 1'b0;
            last_msb  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            word_out  <= word_nxt;
            valid_out <= valid_nxt;
            hs_en_out <= hs_nxt;
            last_msb  <= msb_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        word_nxt     = word_out;
        valid_nxt    = valid_out;
        hs_nxt       = hs_en_out;
        msb_nxt      = last_msb;
        in_ready     = 1'b0;
        err_underrun = 1'b0;

        case (state)
            IDLE: begin
                word_nxt  = '0;
                valid_nxt = '0;
                hs_nxt    = 1'b0;
                if (in_valid) begin
                    state_nxt = ZERO;
                    hs_nxt    = 1'b1;
                    cnt_nxt   = 8'(ZERO_CYCLES - 1);
                end
            end

            ZERO: begin
                if (cnt == 8'd0) begin
                    word_nxt  = {NUM_LANE{SYNC_BYTE}};
                    valid_nxt = '1;
                    msb_nxt   = {NUM_LANE{SYNC_BYTE[7]}};
                    state_nxt = DATA;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end

            DATA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_nxt  = word_in;
                    valid_nxt = '1;
                    for (int i = 0; i < NUM_LANE; i++) begin
                        if (!last_in || (LANE_W'(i) < last_lanes)) begin
                            msb_nxt[i] = word_in[8*i+7];
                        end else begin
                            // lane already finished: start its trail now
                            word_nxt[8*i +: 8] = trail_byte(last_msb[i]);
                            valid_nxt[i]       = 1'b0;
                        end
                    end
                    if (last_in) begin
                        state_nxt = TRAIL;
                        cnt_nxt   = 8'(TRAIL_CYCLES);
                    end
                end else begin
                    err_underrun = 1'b1;
                    valid_nxt    = '0;
                end
            end

            TRAIL: begin
                // counter is loaded with TRAIL_CYCLES; the zero step clears the register
                if (cnt == 8'd0) begin
                    word_nxt  = '0;
                    valid_nxt = '0;
                    hs_nxt    = 1'b0;
                    state_nxt = EXIT;
                end else begin
                    for (int i = 0; i < NUM_LANE; i++) begin
                        word_nxt[8*i +: 8] = trail_byte(last_msb[i]);
                    end
                    valid_nxt = '0;
                    cnt_nxt   = cnt - 8'd1;
                end
            end

            EXIT: begin
                word_nxt  = '0;
                valid_nxt = '0;
                hs_nxt    = 1'b0;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_csi_tx_lane_dist.sv
`default_nettype none
// ============================================================================
// Module   : tb_csi_tx_lane_dist
// Brief    : Self-checking bench for csi_tx_lane_dist against a burst timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csi_tx_lane_dist;

    localparam int NL   = 2;
    localparam int Z    = 4;
    localparam int T    = 3;
    localparam int MAXC = 64;

    logic        byte_clock = 1'b0;
    logic        reset      = 1'b1;
    logic        in_valid   = 1'b0;
    logic        last_in    = 1'b0;
    logic [15:0] word_in    = 16'h0;
    logic [1:0]  last_lanes = 2'd0;
    logic        in_ready;
    logic        hs_en_out;
    logic [15:0] word_out;
    logic [1:0]  valid_out;
    logic        err_underrun;

    csi_tx_lane_dist #(
        .NUM_LANE     (NL),
        .ZERO_CYCLES  (Z),
        .TRAIL_CYCLES (T)
    ) dut (
        .byte_clock   (byte_clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .word_in      (word_in),
        .last_in      (last_in),
        .last_lanes   (last_lanes),
        .hs_en_out    (hs_en_out),
        .word_out     (word_out),
        .valid_out    (valid_out),
        .err_underrun (err_underrun)
    );

    always #5 byte_clock = ~byte_clock;

    int total = 0;
    int bad   = 0;

    // packet description
    logic [15:0] pw[$];
    int          nlast;
    int          gap;
    int          chain;
    int          abort_at;

    // per-cycle timeline: cycle 0 is the IDLE cycle that first sees in_valid
    logic        e_hs   [MAXC];
    logic [15:0] e_word [MAXC];
    logic [1:0]  e_valid[MAXC];
    logic        e_rdy  [MAXC];
    logic        e_err  [MAXC];
    logic        d_v    [MAXC];
    logic        d_l    [MAXC];
    logic [15:0] d_w    [MAXC];
    int          ncyc;
    int          nwait;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic build_model();
        logic [7:0]  lb[NL];
        logic [15:0] cur;
        int          c;
        int          n;
        n = pw.size();
        for (int i = 0; i < MAXC; i++) begin
            e_hs[i] = 1'b0; e_word[i] = 16'h0; e_valid[i] = 2'b00;
            e_rdy[i] = 1'b0; e_err[i] = 1'b0;
            d_v[i] = 1'b0; d_l[i] = 1'b0; d_w[i] = 16'($urandom);
        end
        d_v[0] = 1'b1;
        for (int i = 1; i <= Z; i++) e_hs[i] = 1'b1;
        e_hs[Z+1] = 1'b1; e_word[Z+1] = 16'hB8B8; e_valid[Z+1] = 2'b11;
        for (int k = 0; k < NL; k++) lb[k] = 8'hB8;
        cur = 16'hB8B8;
        c   = Z + 1;
        for (int j = 0; j < n; j++) begin
            if (j == gap) begin
                e_rdy[c] = 1'b1; e_err[c] = 1'b1;
                e_hs[c+1] = 1'b1; e_word[c+1] = cur; e_valid[c+1] = 2'b00;
                c++;
            end
            d_v[c] = 1'b1; d_w[c] = pw[j]; d_l[c] = (j == n - 1);
            e_rdy[c] = 1'b1; e_hs[c+1] = 1'b1;
            for (int k = 0; k < NL; k++) begin
                if (j < n - 1 || k < nlast) begin
                    e_word[c+1][8*k +: 8] = pw[j][8*k +: 8];
                    e_valid[c+1][k]       = 1'b1;
                    lb[k]                 = pw[j][8*k +: 8];
                end else begin
                    e_word[c+1][8*k +: 8] = lb[k][7] ? 8'h00 : 8'hFF;
                    e_valid[c+1][k]       = 1'b0;
                end
            end
            cur = e_word[c+1];
            c++;
        end
        for (int t = 1; t <= T; t++) begin
            e_hs[c+t] = 1'b1;
            for (int k = 0; k < NL; k++) e_word[c+t][8*k +: 8] = lb[k][7] ? 8'h00 : 8'hFF;
        end
        ncyc  = c + T + 2;
        nwait = Z + 1 + n + T + ((gap >= 0 && gap < n) ? 1 : 0);
        if (chain != 0) for (int i = c; i < ncyc; i++) d_v[i] = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " hs"},    32'(hs_en_out),    32'd0);
        check({tag, " word"},  32'(word_out),     32'd0);
        check({tag, " valid"}, 32'(valid_out),    32'd0);
        check({tag, " rdy"},   32'(in_ready),     32'd0);
        check({tag, " err"},   32'(err_underrun), 32'd0);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge byte_clock);
            in_valid = 1'b0; last_in = 1'b0; word_in = 16'($urandom);
            #1;
            check_idle($sformatf("%s i%0d", tag, i));
        end
    endtask

    task automatic run_packet(input int pid);
        int    hs_cnt;
        string tg;
        hs_cnt = 0;
        build_model();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge byte_clock);
            in_valid   = d_v[c];
            word_in    = d_w[c];
            last_in    = d_l[c];
            last_lanes = d_l[c] ? 2'(nlast) : 2'($urandom_range(0, 3));
            if (c == abort_at) reset = 1'b1;
            #1;
            tg = $sformatf("p%0d c%0d", pid, c);
            check({tg, " hs"},    32'(hs_en_out),    32'(e_hs[c]));
            check({tg, " word"},  32'(word_out),     32'(e_word[c]));
            check({tg, " valid"}, 32'(valid_out),    32'(e_valid[c]));
            check({tg, " rdy"},   32'(in_ready),     32'(e_rdy[c]));
            check({tg, " err"},   32'(err_underrun), 32'(e_err[c]));
            hs_cnt += int'(hs_en_out);
            if (c == abort_at) break;
        end
        if (abort_at >= 0) begin
            @(negedge byte_clock);
            reset = 1'b0; in_valid = 1'b0; last_in = 1'b0;
            #1;
            check_idle($sformatf("p%0d after reset", pid));
            idle(T + 2, $sformatf("p%0d no trail", pid));
        end else begin
            check($sformatf("p%0d burst len", pid), 32'(hs_cnt), 32'(nwait));
        end
    endtask

    task automatic set_pkt(input int n_last, input int g, input int ch, input int ab);
        nlast = n_last; gap = g; chain = ch; abort_at = ab;
    endtask

    initial begin
        // reset then idle
        reset = 1'b1;
        repeat (3) @(posedge byte_clock);
        @(negedge byte_clock);
        reset = 1'b0;
        #1;
        check_idle("reset");
        idle(4, "idle");

        // 3-word packet, full final word
        pw = '{16'h1234, 16'h5678, 16'h9A0C};
        set_pkt(2, -1, 0, -1);
        run_packet(1);
        idle(2, "gap1");

        // odd length: final word only lane 0
        pw = '{16'h0102, 16'h0085};
        set_pkt(1, -1, 0, -1);
        run_packet(2);
        idle(1, "gap2");

        // single word, in_valid held through trail/exit into the next packet
        pw = '{16'h7F80};
        set_pkt(2, -1, 1, -1);
        run_packet(3);

        // underrun between payload words
        pw = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
        set_pkt(2, 1, 0, -1);
        run_packet(4);
        idle(2, "gap4");

        // reset at the second payload word
        pw = '{16'h1111, 16'h2222, 16'h3333};
        set_pkt(2, -1, 0, Z + 2);
        run_packet(5);

        // randomized packets
        for (int p = 0; p < 20; p++) begin
            int n;
            n = $urandom_range(1, 6);
            pw.delete();
            for (int j = 0; j < n; j++) pw.push_back(16'($urandom));
            set_pkt($urandom_range(1, 2),
                    ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1,
                    ($urandom_range(0, 3) == 0) ? 1 : 0,
                    -1);
            run_packet(10 + p);
            if (chain == 0) idle($urandom_range(1, 2), $sformatf("rgap%0d", p));
        end
        idle(2, "final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
